gmii_rx_pack: RTL and testbench
===============================

Name: gmii_rx_pack

Overview:
Receive front end that feeds rx_filter. It takes a GMII byte stream and strips preamble and SFD. It packs the frame bytes into 32-bit words with sop, eop, vld and mod, removes the 4-byte FCS, checks CRC-32 and frame length, and flags bad frames on dout_err together with dout_eop. rx_filter consumes dout, dout_sop, dout_eop, dout_vld, dout_mod and dout_err directly as its din_* inputs.

Parameters:
MIN_LEN, 60, minimum frame length in bytes (DA through payload, FCS excluded); shorter frames are flagged as errors.
MAX_LEN, 1514, maximum frame length in bytes (FCS excluded); longer frames are flagged as errors.

Ports:
clk  in  1  system clock; GMII is already synchronous to clk.
rst_n  in  1  reset; synchronous and active-high (1 = reset), despite the name.
gmii_rxd  in  8  receive byte.
gmii_rx_dv  in  1  receive data valid.
gmii_rx_er  in  1  receive error.
dout  out  32  packed word; first byte of the word in [31:24].
dout_sop  out  1  first word of the frame.
dout_eop  out  1  last word of the frame.
dout_vld  out  1  word strobe, one-cycle pulse per word.
dout_mod  out  2  number of invalid trailing bytes in the eop word (0 = all 4 bytes valid); 0 when not eop.
dout_err  out  1  frame bad; valid only with dout_eop, 0 otherwise.

Behaviour:
- Input stage: gmii_rxd, gmii_rx_dv and gmii_rx_er are registered once. All further logic uses the registered copies (rxd_r, dv_r, er_r).
- Reset: all outputs 0, FSM to WAIT_GAP, CRC register to 0xFFFFFFFF, counters and buffers cleared.
- FSM transitions:
  - WAIT_GAP: go to IDLE when dv_r=0. This prevents locking onto mid-frame data after reset.
  - IDLE: go to PRE when dv_r=1 and rxd_r=0x55.
  - PRE: stay on 0x55. Go to DATA on 0xD5. Any other byte goes to WAIT_GAP. dv_r=0 goes to IDLE. No output in PRE.
  - DATA: dv_r=0 ends the frame and goes to IDLE.
- CRC: reflected CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF. It is updated on every DATA byte, FCS included. The frame is good when the register equals the residue 0xDEBB20E3 at end of frame.
- FCS strip: a 4-byte delay line runs in DATA. Only bytes that shift out of the delay line are packed. The 4 bytes left in the delay line at end of frame are the FCS and are discarded.
- Packing:
  - Bytes are packed MSB-first into a 32-bit assembly register, with a 2-bit byte index that wraps 3 to 0.
  - A completed word moves to a 1-word hold register. It is emitted (dout_vld=1, dout_sop=1 if it is the first word) only when the next packed byte arrives, which proves it is not the last word.
  - In steady state there is one word per 4 cycles.
- End of frame: on the cycle dv_r is first 0 in DATA, the held word (or the partial assembly word, zero-padded) is emitted on the next clk edge with dout_eop=1.
  - Latency: dout_eop is high in the cycle after the second clk edge following the first sampled gmii_rx_dv=0.
  - dout_mod = (4 - packed_bytes mod 4) mod 4.
  - A single-word frame carries dout_sop=1 and dout_eop=1 together.
- Length: an 11-bit packed-byte counter, saturating at 2047.
- dout_err=1 if any of the following holds:
  - CRC mismatch;
  - er_r seen in DATA;
  - length < MIN_LEN;
  - length > MAX_LEN.
- Runt frames:
  - 4 or fewer bytes after SFD: no word is emitted and the frame is silently dropped.
  - dv_r falling in PRE: nothing is emitted.
- Back-to-back frames: a 1-cycle dv gap is legal. The eop emission overlaps the next preamble without loss.
- Reset mid-frame: outputs go to 0 immediately on the reset edge. No eop is emitted for the aborted frame. The FSM waits in WAIT_GAP.

Decomposition:
- Shared package eth_rx_pkg:
  - constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, CRC_INIT=0xFFFFFFFF, CRC_RESIDUE=0xDEBB20E3;
  - FSM state encoding (WAIT_GAP, IDLE, PRE, DATA);
  - mod field width.
- One sub-module, crc32_d8: purely combinational next-CRC over 8 data bits, reflected.
- The FSM, delay line, packer and output registers stay in gmii_rx_pack.

Test Plan:
1. 7×0x55, 0xD5, 60 bytes 0x00..0x3B, correct FCS -> 15 words, first dout=0x00010203 with sop, last dout=0x38393A3B with eop, mod=0, err=0.
2. Same frame with 61 payload bytes -> 16 words, eop word=0x3C000000, mod=3, err=0.
3. Case 1 with one FCS byte flipped -> identical words, eop word with err=1.
4. Case 1 with gmii_rx_er pulsed on byte 20 -> err=1. 40-byte payload frame with correct FCS -> err=1 (runt). 1515-byte payload frame -> err=1.
5. Preamble corrupted (0x55,0x55,0x12,...) -> no dout_vld for the whole frame. The following good frame after a 1-cycle gap is received correctly.
6. rst_n pulsed for 1 cycle in the middle of frame 1 -> no eop for frame 1, no output for the rest of frame 1. Frame 2 after the gap matches case 1 exactly.

Source files
------------

// File: rtl/eth_rx_pkg.sv
// Shared definitions for the Ethernet receive path: GMII framing bytes,
// CRC-32 constants, receive FSM encoding and field widths.
package eth_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;
  // Bit-reversed form of 0x04C11DB7 for the LSB-first update.
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

  localparam int unsigned MOD_W = 2;
  localparam int unsigned LEN_W = 11;

  typedef enum logic [1:0] {
    WAIT_GAP = 2'd0,
    IDLE     = 2'd1,
    PRE      = 2'd2,
    DATA     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected CRC-32 over one byte, LSB first.
module crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next_c
);

  always_comb begin
    crc_next_c = crc;
    for (int i = 0; i < 8; i++) begin
      if (crc_next_c[0] ^ data[i]) begin
        crc_next_c = (crc_next_c >> 1) ^ CRC_POLY_REFL;
      end else begin
        crc_next_c = crc_next_c >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_rx_pack.sv
// GMII receive front end: strips preamble/SFD and FCS, packs frame bytes into
// 32-bit words and flags CRC, rx_er and length errors with the eop word.
module gmii_rx_pack
  import eth_rx_pkg::*;
#(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1514
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [31:0]      dout,
  output logic             dout_sop,
  output logic             dout_eop,
  output logic             dout_vld,
  output logic [MOD_W-1:0] dout_mod,
  output logic             dout_err
);

  logic [7:0]       rxd_r;
  logic             dv_r;
  logic             er_r;

  rx_state_e        state;
  rx_state_e        state_nxt;

  logic [31:0]      crc_q;
  logic [31:0]      crc_nxt_c;
  logic [31:0]      dly_q;
  logic [2:0]       dly_cnt_q;
  logic [31:0]      asm_q;
  logic [1:0]       idx_q;
  logic [31:0]      hold_q;
  logic             hold_vld_q;
  logic             first_q;
  logic [LEN_W-1:0] len_q;
  logic             er_seen_q;

  logic             data_byte_c;
  logic             frame_end_c;
  logic             pack_c;
  logic             frame_bad_c;
  logic [7:0]       pack_byte_c;

  // Input retiming; dv resets high so WAIT_GAP only leaves on a real gap.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rxd_r <= 8'h00;
      dv_r  <= 1'b1;
      er_r  <= 1'b0;
    end else begin
      rxd_r <= gmii_rxd;
      dv_r  <= gmii_rx_dv;
      er_r  <= gmii_rx_er;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state <= WAIT_GAP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    data_byte_c = 1'b0;
    frame_end_c = 1'b0;
    pack_c      = 1'b0;
    case (state)
      WAIT_GAP: begin
        if (!dv_r) state_nxt = IDLE;
      end
      IDLE: begin
        if (dv_r && (rxd_r == PREAMBLE_BYTE)) state_nxt = PRE;
      end
      PRE: begin
        if (!dv_r)                       state_nxt = IDLE;
        else if (rxd_r == SFD_BYTE)      state_nxt = DATA;
        else if (rxd_r != PREAMBLE_BYTE) state_nxt = WAIT_GAP;
      end
      DATA: begin
        if (!dv_r) begin
          state_nxt   = IDLE;
          frame_end_c = 1'b1;
        end else begin
          data_byte_c = 1'b1;
          pack_c      = (dly_cnt_q == 3'd4);
        end
      end
      default: state_nxt = WAIT_GAP;
    endcase
  end

  assign pack_byte_c = dly_q[31:24];
  assign frame_bad_c = (crc_q != CRC_RESIDUE) || er_seen_q ||
                       (len_q < LEN_W'(MIN_LEN)) || (len_q > LEN_W'(MAX_LEN));

  crc32_d8 u_crc (
    .crc        (crc_q),
    .data       (rxd_r),
    .crc_next_c (crc_nxt_c)
  );

  // Delay line, packer, hold word and output registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      crc_q      <= CRC_INIT;
      dly_q      <= '0;
      dly_cnt_q  <= '0;
      asm_q      <= '0;
      idx_q      <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      first_q    <= 1'b1;
      len_q      <= '0;
      er_seen_q  <= 1'b0;
      dout       <= '0;
      dout_sop   <= 1'b0;
      dout_eop   <= 1'b0;
      dout_vld   <= 1'b0;
      dout_mod   <= '0;
      dout_err   <= 1'b0;
    end else begin
      dout     <= '0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_vld <= 1'b0;
      dout_mod <= '0;
      dout_err <= 1'b0;

      if (data_byte_c) begin
        crc_q <= crc_nxt_c;
        dly_q <= {dly_q[23:0], rxd_r};
        if (dly_cnt_q != 3'd4) dly_cnt_q <= dly_cnt_q + 3'd1;
        if (er_r) er_seen_q <= 1'b1;

        if (pack_c) begin
          if (len_q != {LEN_W{1'b1}}) len_q <= len_q + LEN_W'(1);
          // A new byte proves the held word is not the frame's last.
          if (hold_vld_q) begin
            dout       <= hold_q;
            dout_vld   <= 1'b1;
            dout_sop   <= first_q;
            first_q    <= 1'b0;
            hold_vld_q <= 1'b0;
          end
          if (idx_q == 2'd3) begin
            hold_q     <= {asm_q[31:8], pack_byte_c};
            hold_vld_q <= 1'b1;
            asm_q      <= '0;
          end else begin
            asm_q <= asm_q | ({pack_byte_c, 24'h000000} >> {idx_q, 3'b000});
          end
          idx_q <= idx_q + 2'd1;
        end
      end else begin
        if (frame_end_c && (hold_vld_q || (idx_q != 2'd0))) begin
          dout     <= hold_vld_q ? hold_q : asm_q;
          dout_vld <= 1'b1;
          dout_sop <= first_q;
          dout_eop <= 1'b1;
          dout_mod <= MOD_W'(2'd0 - idx_q);
          dout_err <= frame_bad_c;
        end
        crc_q      <= CRC_INIT;
        dly_q      <= '0;
        dly_cnt_q  <= '0;
        asm_q      <= '0;
        idx_q      <= '0;
        hold_vld_q <= 1'b0;
        first_q    <= 1'b1;
        len_q      <= '0;
        er_seen_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_pack.sv
// Bench for gmii_rx_pack: directed GMII frames, a frame-level word model and a
// per-cycle output compare against the model's expected word queue.
module tb_gmii_rx_pack;

  localparam int MIN_LEN = 60;
  localparam int MAX_LEN = 1514;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gmii_rxd;
  logic        gmii_rx_dv;
  logic        gmii_rx_er;
  logic [31:0] dout;
  logic        dout_sop;
  logic        dout_eop;
  logic        dout_vld;
  logic [1:0]  dout_mod;
  logic        dout_err;

  always #5 clk = ~clk;

  gmii_rx_pack #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .dout       (dout),
    .dout_sop   (dout_sop),
    .dout_eop   (dout_eop),
    .dout_vld   (dout_vld),
    .dout_mod   (dout_mod),
    .dout_err   (dout_err)
  );

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  mod;
    logic        err;
  } word_t;

  word_t        exp_q[$];
  word_t        fw[$];
  byte unsigned pl[$];
  word_t        cmp_e;
  int           checks = 0;
  int           errors = 0;
  bit           run_cmp = 1'b0;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Expected words for payload pl: MSB-first packing, zero pad, trailing mod.
  task automatic build_words(input bit bad_in);
    int n;
    bit bad;
    word_t e;
    n   = pl.size();
    bad = bad_in || (n < MIN_LEN) || (n > MAX_LEN);
    fw.delete();
    for (int w = 0; w * 4 < n; w++) begin
      e.d = 32'h0;
      for (int k = 0; k < 4; k++) begin
        if (w * 4 + k < n) e.d[31 - 8 * k -: 8] = pl[w * 4 + k];
      end
      e.sop = (w == 0);
      e.eop = (w * 4 + 4 >= n);
      e.mod = e.eop ? 2'((4 - (n % 4)) % 4) : 2'd0;
      e.err = e.eop ? bad : 1'b0;
      fw.push_back(e);
    end
  endtask

  task automatic send_frame(input bit corrupt_pre, input int flip_idx, input int er_idx,
                            input int rst_idx, input int gap, input bit lat_chk);
    logic [31:0]  c;
    byte unsigned fr[$];
    c = 32'hFFFFFFFF;
    foreach (pl[i]) c = crc_upd(c, pl[i]);
    c  = ~c;
    fr = pl;
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    fr.push_back(c[23:16]);
    fr.push_back(c[31:24]);
    if (flip_idx >= 0) fr[pl.size() + flip_idx] = fr[pl.size() + flip_idx] ^ 8'h01;
    if (!corrupt_pre && rst_idx < 0) begin
      build_words((flip_idx >= 0) || (er_idx >= 0));
      foreach (fw[i]) exp_q.push_back(fw[i]);
    end else begin
      fw.delete();
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rx_er = 1'b0;
      gmii_rxd   = (i == 7) ? 8'hD5 : ((corrupt_pre && i == 2) ? 8'h12 : 8'h55);
    end
    for (int i = 0; i < fr.size(); i++) begin
      @(posedge clk); #1;
      gmii_rx_dv = 1'b1;
      gmii_rxd   = fr[i];
      gmii_rx_er = (i == er_idx);
      rst_n      = (i == rst_idx);
    end
    @(posedge clk); #1;
    gmii_rx_dv = 1'b0;
    gmii_rx_er = 1'b0;
    gmii_rxd   = 8'h00;
    rst_n      = 1'b0;
    if (lat_chk) begin
      @(posedge clk); @(negedge clk);
      chk("eop_not_early", 32'(dout_eop), 32'd0);
      @(posedge clk); @(negedge clk);
      chk("eop_latency", 32'(dout_eop), 32'd1);
      repeat (gap - 2) @(posedge clk);
    end else begin
      repeat (gap - 1) @(posedge clk);
    end
  endtask

  task automatic fill_seq(input int n);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'(i));
  endtask

  always @(negedge clk) begin
    if (run_cmp) begin
      checks++;
      if (dout_vld) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got dout=%h sop=%b eop=%b mod=%0d err=%b, expected no word",
                   dout, dout_sop, dout_eop, dout_mod, dout_err);
        end else begin
          cmp_e = exp_q.pop_front();
          if ({dout, dout_sop, dout_eop, dout_mod, dout_err} !==
              {cmp_e.d, cmp_e.sop, cmp_e.eop, cmp_e.mod, cmp_e.err}) begin
            errors++;
            $display("FAIL word: got dout=%h sop=%b eop=%b mod=%0d err=%b expected dout=%h sop=%b eop=%b mod=%0d err=%b",
                     dout, dout_sop, dout_eop, dout_mod, dout_err,
                     cmp_e.d, cmp_e.sop, cmp_e.eop, cmp_e.mod, cmp_e.err);
          end
        end
      end else if ({dout_sop, dout_eop, dout_mod, dout_err} !== 5'b0) begin
        errors++;
        $display("FAIL idle_fields: got sop=%b eop=%b mod=%0d err=%b expected all 0 without vld",
                 dout_sop, dout_eop, dout_mod, dout_err);
      end
    end
  end

  initial begin
    logic [31:0] c;
    byte unsigned chk_str[$];
    rst_n      = 1'b1;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    gmii_rx_er = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_vld", 32'(dout_vld), 32'd0);
    chk("reset_dout", dout, 32'd0);
    chk("reset_flags", 32'({dout_sop, dout_eop, dout_mod, dout_err}), 32'd0);
    rst_n   = 1'b0;
    run_cmp = 1'b1;

    // CRC model pinned to the standard check value of "123456789".
    chk_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 32'hFFFFFFFF;
    foreach (chk_str[i]) c = crc_upd(c, chk_str[i]);
    chk("crc_model_check", ~c, 32'hCBF43926);

    fill_seq(60);
    send_frame(1'b0, -1, -1, -1, 3, 1'b1);
    chk("t1_word_count", 32'(fw.size()), 32'd15);
    chk("t1_first_word", fw[0].d, 32'h00010203);
    chk("t1_first_sop", 32'(fw[0].sop), 32'd1);
    chk("t1_last_word", fw[14].d, 32'h38393A3B);
    chk("t1_last_flags", 32'({fw[14].eop, fw[14].mod, fw[14].err}), 32'b1000);

    fill_seq(61);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);
    chk("t2_word_count", 32'(fw.size()), 32'd16);
    chk("t2_last_word", fw[15].d, 32'h3C000000);
    chk("t2_last_mod", 32'(fw[15].mod), 32'd3);

    fill_seq(60);
    send_frame(1'b0, 1, -1, -1, 1, 1'b0);
    chk("t3_fcs_err", 32'(fw[14].err), 32'd1);

    send_frame(1'b0, -1, 20, -1, 1, 1'b0);
    chk("t4_rxer_err", 32'(fw[14].err), 32'd1);

    fill_seq(40);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);
    chk("t4_runt_err", 32'({fw[9].eop, fw[9].err}), 32'b11);

    fill_seq(1515);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);
    chk("t4_long_err", 32'(fw[fw.size() - 1].err), 32'd1);

    fill_seq(1514);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);
    chk("max_len_ok", 32'(fw[fw.size() - 1].err), 32'd0);

    fill_seq(3);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);
    chk("one_word_flags", 32'({fw[0].sop, fw[0].eop, fw[0].mod}), 32'b1101);

    fill_seq(0);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);
    chk("fcs_only_dropped", 32'(fw.size()), 32'd0);

    fill_seq(60);
    send_frame(1'b1, -1, -1, -1, 1, 1'b0);
    send_frame(1'b0, -1, -1, -1, 1, 1'b0);

    send_frame(1'b0, -1, -1, 6, 1, 1'b0);
    send_frame(1'b0, -1, -1, -1, 3, 1'b0);
    chk("t6_frame2_last", fw[14].d, 32'h38393A3B);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("all_words_seen", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
